seg_display_scan: RTL and testbench

- Time-multiplexes the four 7-bit active-low digit patterns produced by the minute/second digit-to-segment stage onto a single shared 4-digit seven-segment display.
- Consumes the 28-bit pattern bus combinationally from that stage. Drives the board's anode and cathode pins directly.
- Adds adjust-mode blinking of the minutes pair or the seconds pair.

---
 rtl/seg_display_scan_pkg.sv | 14 +
 rtl/seg_display_scan_tick_divider.sv | 22 ++
 rtl/seg_display_scan.sv | 78 +++++++
 tb/tb_seg_display_scan.sv | 117 +++++++++++
 4 files changed

// File: rtl/seg_display_scan_pkg.sv
// seg_display_scan_pkg: anode/segment codes, digit index width and blink pair-select encoding
package seg_display_scan_pkg;
    localparam int IDX_W = 2;
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b0111;
    localparam logic [3:0] AN_DIG1 = 4'b1011;
    localparam logic [3:0] AN_DIG2 = 4'b1101;
    localparam logic [3:0] AN_DIG3 = 4'b1110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    typedef enum logic {PAIR_MIN = 1'b0, PAIR_SEC = 1'b1} pair_sel_e;
    function automatic logic [3:0] an_code(input logic [IDX_W-1:0] idx);
        return idx == 2'd0 ? AN_DIG0 : idx == 2'd1 ? AN_DIG1 : idx == 2'd2 ? AN_DIG2 : AN_DIG3;
    endfunction
endpackage

// File: rtl/seg_display_scan_tick_divider.sv
// tick_divider: free-running modulo-DIV counter with synchronous clear and a wrap pulse
module tick_divider #(
    parameter int DIV = 2,
    localparam int W = DIV > 1 ? $clog2(DIV) : 1
) (
    input  logic         in_clk,
    input  logic         in_rst_n,
    input  logic         in_clr,
    output logic [W-1:0] out_cnt,
    output logic         out_wrap
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        out_wrap = !in_clr && cnt_q == W'(DIV - 1);
        cnt_d    = (in_clr || out_wrap) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end
    assign out_cnt = cnt_q;
endmodule

// File: rtl/seg_display_scan.sv
// seg_display_scan: 4-digit seven-segment scanner with adjust-mode pair blinking.
// Optional macro SEG_SCAN_BLANK_EN blanks anodes for the first BLANK_CYCLES of every slot.
module seg_display_scan
    import seg_display_scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_DIV    = 25000000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic [27:0] in_bcds,
    input  logic        in_adj,
    input  logic        in_sel,
    output logic [3:0]  out_an,
    output logic [6:0]  out_seg
);
    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam int UNUSED_BLANK = BLANK_CYCLES;

    logic [RW-1:0]    ref_cnt;
    logic [BW-1:0]    blk_cnt;
    logic             ref_wrap, blk_wrap;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             phase_q, phase_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             in_pair, dark, guard;
    pair_sel_e        sel;
    logic             unused_cnt;

    tick_divider #(.DIV(REFRESH_DIV)) u_refresh (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_clr(1'b0),
        .out_cnt(ref_cnt), .out_wrap(ref_wrap)
    );
    tick_divider #(.DIV(BLINK_DIV)) u_blink (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_clr(!in_adj),
        .out_cnt(blk_cnt), .out_wrap(blk_wrap)
    );

    assign sel        = pair_sel_e'(in_sel);
    assign unused_cnt = ^{ref_cnt, blk_cnt};

    always_comb begin
        idx_d   = ref_wrap ? idx_q + 1'b1 : idx_q;
        phase_d = !in_adj ? 1'b1 : blk_wrap ? !phase_q : phase_q;
        in_pair = (sel == PAIR_SEC) ? idx_q[1] : !idx_q[1];
        // forcing is gated by the live in_adj so leaving adjust lights the pair at once
        dark    = in_adj && !phase_q && in_pair;
`ifdef SEG_SCAN_BLANK_EN
        guard   = int'(ref_cnt) < BLANK_CYCLES;
`else
        guard   = 1'b0;
`endif
        an_d    = (dark || guard) ? AN_OFF : an_code(idx_q);
        seg_d   = idx_q == 2'd0 ? in_bcds[27:21] :
                  idx_q == 2'd1 ? in_bcds[20:14] :
                  idx_q == 2'd2 ? in_bcds[13:7]  : in_bcds[6:0];
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            idx_q   <= '0;
            phase_q <= 1'b1;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
        end else begin
            idx_q   <= idx_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign out_an  = an_q;
    assign out_seg = seg_q;
endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan: scoreboard bench; expectations come from an arithmetic cycle-count model
module tb_seg_display_scan;
    localparam int R = 4;
    localparam int B = 8;
    localparam int BLANK = 1;
    localparam logic [27:0] BCDS = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [27:0] bcds = BCDS;
    logic        adj = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_edges = 0;
    int   adj_cnt = 0;

    seg_display_scan #(.REFRESH_DIV(R), .BLINK_DIV(B), .BLANK_CYCLES(BLANK)) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_bcds(bcds), .in_adj(adj), .in_sel(sel),
        .out_an(an), .out_seg(seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // expected pins for the coming edge, from edges since release and adjust-held edges
    task automatic cycle(input string tag);
        int idx;
        bit vis, dark, guard;
        exp_t e, g;
        idx   = (n_edges / R) % 4;
        vis   = ((adj_cnt / B) % 2) == 0;
        dark  = adj && !vis && ((idx / 2) == int'(sel));
        guard = 1'b0;
`ifdef SEG_SCAN_BLANK_EN
        guard = (n_edges % R) < BLANK;
`endif
        e.an  = (dark || guard) ? 4'b1111 : ~(4'b1000 >> idx);
        e.seg = 7'(bcds >> (7 * (3 - idx)));
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_edges++;
        adj_cnt = adj ? adj_cnt + 1 : 0;
        g = sb.pop_front();
        chk({tag, "_an"}, 32'(an), 32'(g.an));
        chk({tag, "_seg"}, 32'(seg), 32'(g.seg));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_an", 32'(an), 32'hF);
        rst_n   = 1'b1;
        n_edges = 0;
        adj_cnt = 0;
    endtask

    initial begin
        bit done;
        #2;
        do_reset();
        for (int i = 0; i < 20; i++) cycle("scan");
        do_reset();
        for (int i = 0; i < 6; i++) cycle("pre_rst");
        do_reset();
        for (int i = 0; i < 8; i++) cycle("post_rst");
        do_reset();
        adj = 1'b1;
        sel = 1'b0;
        for (int i = 0; i < 40; i++) cycle("min_blink");
        sel = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            cycle("sec_blink");
            done = ((adj_cnt / B) % 2) == 1 && ((n_edges / R) % 4) >= 2;
        end
        chk("dark_reached", 32'(done), 32'd1);
        adj = 1'b0;
        cycle("exit");
        cycle("exit_hold");
        adj = 1'b1;
        for (int i = 0; i < 24; i++) cycle("reenter");
        sel = 1'b0;
        for (int i = 0; i < 12; i++) cycle("sel_flip");
        adj = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 32 && !done; i++) begin
            cycle("pre_live");
            done = ((n_edges / R) % 4) == 3 && (n_edges % R) == 1;
        end
        chk("live_reached", 32'(done), 32'd1);
        bcds[6:0] = 7'b0000001;
        for (int i = 0; i < 10; i++) cycle("live");
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
